mdu_unit: RTL
=============

// Module: mdu_unit
// PURPOSE
//   Multiply/divide unit in the E stage. It executes the MDU operations that the instruction
//   decoder issues via MDUOp/MDUStart: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
//   It holds the architectural HI/LO registers and models the multi-cycle latency of mult/div.
//   Busy/Start feed the hazard unit, which stalls later MDU instructions in D.
// PARAMETERS
//   MULT_CYCLES  5   Busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  Busy cycles for div/divu (>=1)
// PORTS
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous, active-high; clears all state
//   MDUOp     in   5   0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo
//   MDUValid  in   1   E-stage instruction is an MDU op (mcal|mf|mt); qualifies MDUOp
//   MDUStart  in   1   E-stage instruction is mult/multu/div/divu
//   A         in   32  rs operand (forwarded)
//   B         in   32  rt operand (forwarded)
//   Busy      out  1   computation in progress
//   HI        out  32  architectural HI
//   LO        out  32  architectural LO
//   MDUOut    out  32  mfhi ? HI : LO (combinational; HI when MDUOp==4, LO otherwise)
// BEHAVIOUR
//   - Reset (async, any cycle, including mid-operation): Busy=0, HI=0, LO=0,
//     counter=0, pending results=0. No commit happens after reset.
//   - Idle state (Busy=0), MDUStart=1 at edge T:
//     - Compute the 64-bit result from A/B and store it in hidden regs pHI/pLO.
//     - Load counter with MULT_CYCLES or DIV_CYCLES.
//     - Busy=1 from T+1.
//   - BUSY state:
//     - The counter decrements each edge.
//     - At the edge where counter==1: HI<=pHI, LO<=pLO, Busy<=0.
//     - So Busy is high for exactly N cycles, and new HI/LO are visible in the first cycle Busy=0.
//   - Start or mt while Busy=1 or MDUStart pending: ignored.
//     The hazard unit guarantees this never occurs; assert it in simulation.
//   - mult: {HI,LO} = $signed(A) * $signed(B). multu: unsigned 64-bit product.
//   - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//     0x80000000 / -1 -> LO=0x80000000, HI=0.
//   - divu: unsigned quotient/remainder.
//   - Divide by zero (div/divu, B==0): still Busy for DIV_CYCLES; HI/LO keep their prior values.
//   - mthi/mtlo: when MDUValid and Busy=0, HI or LO <= A at the next edge (1-cycle write).
//   - mfhi/mflo: no state change. MDUOut reflects current HI/LO in the same cycle.
//     No HI/LO bypass is needed, because the stall covers the producer.
//   - MDUValid=0: MDUOp is ignored (decoder default 0 == mult must not start anything);
//     MDUStart is gated with MDUValid.
//   - State machine: IDLE -(valid start)-> BUSY -(counter==1)-> IDLE; reset -> IDLE from any state.
// TESTING
//   1. mult A=0xFFFFFFFF B=2 -> Busy for exactly 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE;
//      multu same operands -> HI=0x00000001 LO=0xFFFFFFFE.
//   2. div A=0xFFFFFFF9(-7) B=2 -> Busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF;
//      divu A=7 B=2 -> LO=3 HI=1.
//   3. mthi A=0x00001234 while idle -> HI=0x00001234 next cycle; mflo -> MDUOut=LO same cycle;
//      mtlo issued during Busy -> LO unchanged.
//   4. HI=5 LO=6, divu A=9 B=0 -> Busy 10 cycles, HI=5 LO=6 afterwards;
//      div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000 HI=0.
//   5. Start mult, assert reset in busy cycle 3 -> Busy/HI/LO=0 immediately, no commit later;
//      after reset release a new mult completes normally.
//   6. MDUValid=0, MDUOp=0, MDUStart=0 for 20 cycles -> Busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : E-stage multiply/divide unit holding architectural HI/LO with
//               fixed multi-cycle mult/div latency and 1-cycle mthi/mtlo.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  MDUOp,
    input  logic        MDUValid,
    input  logic        MDUStart,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1) + 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_phi;
    logic [31:0]        r_plo;
    logic               r_pvalid;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic        w_start;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_is_div;
    logic        w_b_zero;
    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_uden;
    logic [31:0] w_sden;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_mq;
    logic [31:0] w_mr;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [63:0] w_res;

    assign w_start  = MDUValid && MDUStart && (MDUOp <= 5'd3) && (r_state == c_ST_IDLE);
    assign w_mthi   = MDUValid && !MDUStart && (MDUOp == 5'd6) && (r_state == c_ST_IDLE);
    assign w_mtlo   = MDUValid && !MDUStart && (MDUOp == 5'd7) && (r_state == c_ST_IDLE);
    assign w_is_div = MDUOp[1];
    assign w_b_zero = (B == 32'd0);

    assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_umul = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign w_a_mag = A[31] ? (~A + 32'd1) : A;
    assign w_b_mag = B[31] ? (~B + 32'd1) : B;
    assign w_uden  = w_b_zero ? 32'd1 : B;
    assign w_sden  = w_b_zero ? 32'd1 : w_b_mag;
    assign w_uq    = A / w_uden;
    assign w_ur    = A % w_uden;
    assign w_mq    = w_a_mag / w_sden;
    assign w_mr    = w_a_mag % w_sden;
    assign w_sq    = (A[31] ^ B[31]) ? (~w_mq + 32'd1) : w_mq;
    assign w_sr    = A[31] ? (~w_mr + 32'd1) : w_mr;

    always_comb begin
        w_res = 64'd0;
        case (MDUOp[1:0])
            2'd0:    w_res = w_smul;
            2'd1:    w_res = w_umul;
            2'd2:    w_res = {w_sr, w_sq};
            default: w_res = {w_ur, w_uq};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_phi    <= 32'd0;
            r_plo    <= 32'd0;
            r_pvalid <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_phi    <= w_res[63:32];
                        r_plo    <= w_res[31:0];
                        r_pvalid <= !(w_is_div && w_b_zero);
                        r_cnt    <= w_is_div ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
                        r_state  <= c_ST_BUSY;
                    end else begin
                        if (w_mthi) r_hi <= A;
                        if (w_mtlo) r_lo <= A;
                    end
                end
                c_ST_BUSY: begin
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                        if (r_pvalid) begin
                            r_hi <= r_phi;
                            r_lo <= r_plo;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(MDUValid && MDUStart && Busy))
                else $error("mdu_unit: MDU start issued while busy");
        end
    end
`endif

    assign Busy   = (r_state == c_ST_BUSY);
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign MDUOut = (MDUOp == 5'd4) ? r_hi : r_lo;

endmodule
`default_nettype wire
